// File: rtl/lcd_pkg.sv
// +---------------------------------------------------------------------------+
// | lcd_pkg: state encoding, HD44780 command bytes and ASCII constants shared |
// | by the LCD write sequencer.                        Revision: 1.0          |
// +---------------------------------------------------------------------------+
`default_nettype none

package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD_L1 = 3'd1,
      ST_LINE1  = 3'd2,
      ST_CMD_L2 = 3'd3,
      ST_LINE2  = 3'd4,
      ST_FINISH = 3'd5
   } state_t;

   localparam logic [7:0] LCD_CMD_LINE1      = 8'h80;
   localparam logic [7:0] LCD_CMD_LINE2      = 8'hC0;
   localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h38;
   localparam logic [7:0] LCD_CMD_DISP_ON    = 8'h0C;
   localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
   localparam logic [7:0] LCD_CMD_ENTRY_MODE = 8'h06;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_EQ    = 8'h3D;
   localparam logic [7:0] ASCII_UC_O  = 8'h4F;
   localparam logic [7:0] ASCII_UC_P  = 8'h50;
   localparam logic [7:0] ASCII_UC_R  = 8'h52;
   localparam logic [7:0] ASCII_UC_V  = 8'h56;
   localparam logic [7:0] ASCII_UC_L  = 8'h4C;
   localparam logic [7:0] ASCII_LC_X  = 8'h78;

   localparam logic [3:0] LAST_INDEX = 4'd15;

endpackage

`default_nettype wire

// File: rtl/hex_to_ascii.sv
// +---------------------------------------------------------------------------+
// | hex_to_ascii: combinational nibble to uppercase ASCII hex digit.          |
// |                                                    Revision: 1.0          |
// +---------------------------------------------------------------------------+
`default_nettype none

module hex_to_ascii
   import lcd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   always_comb begin
      if (nibble < 4'd10) begin
         ascii = ASCII_ZERO + {4'd0, nibble};
      end else begin
         ascii = ASCII_A + {4'd0, nibble} - 8'd10;
      end
   end

endmodule

`default_nettype wire

// File: rtl/lcd_write_sequencer.sv
// +---------------------------------------------------------------------------+
// | lcd_write_sequencer: emits a 34-byte two-line status refresh to an LCD    |
// | byte writer using a req/ack handshake.             Revision: 1.0          |
// +---------------------------------------------------------------------------+
`default_nettype none

module lcd_write_sequencer
   import lcd_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  opcode,
   input  logic [3:0]  dest_reg_addr,
   input  logic [15:0] alu_result,
   output logic        busy,
   output logic        done,
   output logic        wr_req,
   output logic        wr_rs,
   output logic [7:0]  wr_data,
   input  logic        wr_ack
);

   state_t      state;
   state_t      next_state;
   logic [3:0]  index;
   logic [3:0]  opcode_q;
   logic [3:0]  dest_q;
   logic [15:0] alu_q;
   logic        req_q;
   logic        ack_ok;
   logic        issuing;
   logic [3:0]  nibble;
   logic [7:0]  hex_char;
   logic [7:0]  byte_sel;

   // An ack only counts while a request is outstanding.
   assign ack_ok  = req_q & wr_ack;
   assign issuing = (state == ST_CMD_L1) || (state == ST_LINE1) ||
                    (state == ST_CMD_L2) || (state == ST_LINE2);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (start) next_state = ST_CMD_L1;
         ST_CMD_L1: if (ack_ok) next_state = ST_LINE1;
         ST_LINE1:  if (ack_ok && index == LAST_INDEX) next_state = ST_CMD_L2;
         ST_CMD_L2: if (ack_ok) next_state = ST_LINE2;
         ST_LINE2:  if (ack_ok && index == LAST_INDEX) next_state = ST_FINISH;
         ST_FINISH: next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         index    <= 4'd0;
         opcode_q <= 4'd0;
         dest_q   <= 4'd0;
         alu_q    <= 16'd0;
         req_q    <= 1'b0;
      end else begin
         if (state == ST_IDLE && start) begin
            opcode_q <= opcode;
            dest_q   <= dest_reg_addr;
            alu_q    <= alu_result;
         end
         if (ack_ok && (state == ST_CMD_L1 || state == ST_CMD_L2)) begin
            index <= 4'd0;
         end else if (ack_ok && (state == ST_LINE1 || state == ST_LINE2)) begin
            index <= index + 4'd1;
         end
         // Dropping req on the ack edge guarantees a one-cycle gap before the next byte.
         if (ack_ok) begin
            req_q <= 1'b0;
         end else if (issuing && !req_q) begin
            req_q <= 1'b1;
         end
      end
   end

   always_comb begin
      nibble = 4'd0;
      if (state == ST_LINE1) begin
         if (index == 4'd3)      nibble = opcode_q;
         else if (index == 4'd7) nibble = dest_q;
      end else if (state == ST_LINE2) begin
         case (index)
            4'd6:    nibble = alu_q[15:12];
            4'd7:    nibble = alu_q[11:8];
            4'd8:    nibble = alu_q[7:4];
            4'd9:    nibble = alu_q[3:0];
            default: nibble = 4'd0;
         endcase
      end
   end

   hex_to_ascii u_hex_to_ascii (
      .nibble (nibble),
      .ascii  (hex_char)
   );

   always_comb begin
      byte_sel = ASCII_SPACE;
      case (state)
         ST_CMD_L1: byte_sel = LCD_CMD_LINE1;
         ST_CMD_L2: byte_sel = LCD_CMD_LINE2;
         ST_LINE1: begin
            case (index)
               4'd0:    byte_sel = ASCII_UC_O;
               4'd1:    byte_sel = ASCII_UC_P;
               4'd2:    byte_sel = ASCII_EQ;
               4'd3:    byte_sel = hex_char;
               4'd4:    byte_sel = ASCII_SPACE;
               4'd5:    byte_sel = ASCII_UC_R;
               4'd6:    byte_sel = ASCII_EQ;
               4'd7:    byte_sel = hex_char;
               default: byte_sel = ASCII_SPACE;
            endcase
         end
         ST_LINE2: begin
            case (index)
               4'd0:    byte_sel = ASCII_UC_V;
               4'd1:    byte_sel = ASCII_A;
               4'd2:    byte_sel = ASCII_UC_L;
               4'd3:    byte_sel = ASCII_EQ;
               4'd4:    byte_sel = ASCII_ZERO;
               4'd5:    byte_sel = ASCII_LC_X;
               4'd6, 4'd7, 4'd8, 4'd9: byte_sel = hex_char;
               default: byte_sel = ASCII_SPACE;
            endcase
         end
         default: byte_sel = ASCII_SPACE;
      endcase
   end

   always_comb begin
      wr_req  = req_q;
      wr_rs   = req_q && (state == ST_LINE1 || state == ST_LINE2);
      wr_data = req_q ? byte_sel : 8'h00;
      busy    = (state != ST_IDLE) && (state != ST_FINISH);
      done    = (state == ST_FINISH);
   end

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_sequencer.sv
// +---------------------------------------------------------------------------+
// | tb_lcd_write_sequencer: directed self-checking bench for the LCD write    |
// | sequencer.                                         Revision: 1.0          |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_lcd_write_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [3:0]  opcode;
   logic [3:0]  dest_reg_addr;
   logic [15:0] alu_result;
   logic        busy;
   logic        done;
   logic        wr_req;
   logic        wr_rs;
   logic [7:0]  wr_data;
   logic        wr_ack;

   int n_cmp;
   int n_err;

   lcd_write_sequencer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .opcode        (opcode),
      .dest_reg_addr (dest_reg_addr),
      .alu_result    (alu_result),
      .busy          (busy),
      .done          (done),
      .wr_req        (wr_req),
      .wr_rs         (wr_rs),
      .wr_data       (wr_data),
      .wr_ack        (wr_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one refresh; hold_byte stretches one ack to 100 cycles, mid_byte pulses a
   // second start with altered operands, abort_byte asserts reset while that byte is
   // requested, spurious keeps wr_ack high through the inter-byte gap.
   task automatic run_refresh(input logic [3:0] op, input logic [3:0] dst,
                              input logic [15:0] alu, input string l1, input string l2,
                              input int hold_byte, input int mid_byte,
                              input int abort_byte, input bit spurious, input string tag);
      logic [8:0] exp_b [34];
      logic       got_rs;
      logic [7:0] got_d;
      int         cnt;
      int         unstable;
      int         gap_bad;
      int         extra;
      exp_b[0]  = {1'b0, 8'h80};
      exp_b[17] = {1'b0, 8'hC0};
      for (int i = 0; i < 16; i++) begin
         exp_b[1 + i]  = {1'b1, l1[i]};
         exp_b[18 + i] = {1'b1, l2[i]};
      end
      gap_bad       = 0;
      opcode        = op;
      dest_reg_addr = dst;
      alu_result    = alu;
      start         = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
      for (int b = 0; b < 34; b++) begin
         if (b == mid_byte) begin
            opcode        = ~op;
            dest_reg_addr = ~dst;
            alu_result    = ~alu;
            start         = 1'b1;
            tick();
            start = 1'b0;
         end
         cnt = 0;
         while (wr_req !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
         end
         if (wr_req !== 1'b1) begin
            chk($sformatf("%s_req_timeout_b%0d", tag, b), {31'd0, wr_req}, 32'd1);
            return;
         end
         if (b == abort_byte) begin
            reset_n = 1'b0;
            #1;
            chk({tag, "_abort_outputs"},
                {20'd0, wr_req, wr_rs, wr_data, busy, done}, 32'd0);
            return;
         end
         got_rs   = wr_rs;
         got_d    = wr_data;
         unstable = 0;
         repeat ((b == hold_byte) ? 100 : 2) begin
            tick();
            if (wr_req !== 1'b1 || wr_rs !== got_rs || wr_data !== got_d) unstable++;
         end
         if (b == hold_byte) chk({tag, "_hold_stable"}, unstable, 32'd0);
         chk($sformatf("%s_byte%0d", tag, b), {23'd0, got_rs, got_d}, {23'd0, exp_b[b]});
         wr_ack = 1'b1;
         tick();
         if (wr_req !== 1'b0) gap_bad++;
         if (spurious && b < 33) tick();
         wr_ack = 1'b0;
      end
      chk({tag, "_req_gap"}, gap_bad, 32'd0);
      chk({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd2);
      tick();
      chk({tag, "_done_clear"}, {30'd0, done, busy}, 32'd0);
      extra = 0;
      repeat (5) begin
         tick();
         if (wr_req !== 1'b0 || done !== 1'b0) extra++;
      end
      chk({tag, "_no_extra_bytes"}, extra, 32'd0);
   endtask

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      reset_n       = 1'b0;
      start         = 1'b0;
      opcode        = 4'h0;
      dest_reg_addr = 4'h0;
      alu_result    = 16'h0;
      wr_ack        = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", {20'd0, wr_req, wr_rs, wr_data, busy, done}, 32'd0);
      reset_n = 1'b1;
      tick();

      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      tick();
      chk("idle_spurious_ack", {30'd0, busy, wr_req}, 32'd0);

      run_refresh(4'h3, 4'hA, 16'h12EF, "OP=3 R=A        ", "VAL=0x12EF      ",
                  -1, -1, -1, 1'b0, "basic");
      run_refresh(4'hF, 4'h0, 16'hFFFF, "OP=F R=0        ", "VAL=0xFFFF      ",
                  -1, -1, -1, 1'b0, "allf");
      run_refresh(4'h5, 4'hC, 16'hA0B9, "OP=5 R=C        ", "VAL=0xA0B9      ",
                  -1, 6, -1, 1'b0, "midstart");
      run_refresh(4'h9, 4'h7, 16'h0000, "OP=9 R=7        ", "VAL=0x0000      ",
                  5, -1, -1, 1'b0, "hold");
      run_refresh(4'h1, 4'h2, 16'h3456, "OP=1 R=2        ", "VAL=0x3456      ",
                  -1, -1, 20, 1'b0, "abort");
      tick();
      tick();
      chk("abort_held_outputs", {20'd0, wr_req, wr_rs, wr_data, busy, done}, 32'd0);
      reset_n = 1'b1;
      wr_ack  = 1'b1;
      tick();
      wr_ack = 1'b0;
      tick();
      tick();
      chk("post_reset_ack_ignored", {30'd0, busy, wr_req}, 32'd0);
      run_refresh(4'hE, 4'hD, 16'hBEEF, "OP=E R=D        ", "VAL=0xBEEF      ",
                  -1, -1, -1, 1'b1, "spurious");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
